// File: rtl/spram_bus_ctrl_pkg.sv
// rtl/spram_bus_ctrl_pkg.sv - shared types and constants for the SPRAM bus controller
package spram_bus_pkg;

  localparam int BANK_WORDS = 16384;
  localparam int BANK_BYTES = 65536;
  localparam int ADR_W      = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Word index inside a bank from a bank-relative byte offset.
  function automatic logic [ADR_W-1:0] word_of(input logic [31:0] off);
    return ADR_W'(off[31:2] % 30'(BANK_WORDS));
  endfunction

endpackage

// File: rtl/spram_bus_ctrl_if.sv
// rtl/spram_bus_ctrl_if.sv - two requester ports plus banked RAM pins
interface spram_bus_ctrl_if
  import spram_bus_pkg::*;
#(
  parameter int BANKS = 2
);
  logic                  m0_valid;
  logic [31:0]           m0_addr;
  logic [31:0]           m0_wdata;
  logic [3:0]            m0_wstrb;
  logic                  m0_ready;
  logic [31:0]           m0_rdata;
  logic                  m1_valid;
  logic [31:0]           m1_addr;
  logic [31:0]           m1_wdata;
  logic [3:0]            m1_wstrb;
  logic                  m1_ready;
  logic [31:0]           m1_rdata;
  logic [BANKS-1:0]      ram_cs;
  logic [3:0]            ram_wren;
  logic [ADR_W-1:0]      ram_adr;
  logic [31:0]           ram_di;
  logic [BANKS*32-1:0]   ram_do;
  logic                  err;

  modport master (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb,
    output ram_do,
    input  m0_ready, m0_rdata, m1_ready, m1_rdata,
    input  ram_cs, ram_wren, ram_adr, ram_di, err
  );

  modport slave (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
    input  ram_do,
    output m0_ready, m0_rdata, m1_ready, m1_rdata,
    output ram_cs, ram_wren, ram_adr, ram_di, err
  );
endinterface

// File: rtl/spram_bus_ctrl_rr_arb2.sv
// rtl/spram_bus_ctrl_rr_arb2.sv - two-way round-robin arbiter with last-grant memory
module rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  // Set when port 1 was granted most recently; reset state hands port 0 the first win.
  logic last_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) last_q <= 1'b1;
    else if (en && (|req)) last_q <= gnt[1];
  end
endmodule

// File: rtl/spram_bus_ctrl.sv
// rtl/spram_bus_ctrl.sv - arbitrated two-port initiator for banked 16Kx32 SPRAM
module spram_bus_ctrl
  import spram_bus_pkg::*;
#(
  parameter int          BANKS     = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            resetn,
  spram_bus_ctrl_if.slave bus
);
  localparam logic [31:0] SPAN = 32'(BANKS) * 32'(BANK_BYTES);

  state_t           state_q, state_d;
  logic [1:0]       req, gnt;
  logic [31:0]      addr_c, wdata_c, off_c;
  logic [3:0]       wstrb_c;
  logic             below_c, oor_c;
  logic [1:0]       bank_c;
  logic [BANKS-1:0] cs_c;
  logic             gnt1_q, oor_q, rd_q, hit;
  logic [1:0]       bank_q;
  logic [31:0]      bank_do;

  assign req = {bus.m1_valid, bus.m0_valid};

  rr_arb2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .en     (state_q == IDLE),
    .req    (req),
    .gnt    (gnt)
  );

  always_comb begin
    addr_c  = gnt[1] ? bus.m1_addr  : bus.m0_addr;
    wdata_c = gnt[1] ? bus.m1_wdata : bus.m0_wdata;
    wstrb_c = gnt[1] ? bus.m1_wstrb : bus.m0_wstrb;
  end

  // The borrow of the offset subtraction flags addresses below the window.
  assign {below_c, off_c} = {1'b0, addr_c} - {1'b0, BASE_ADDR};
  assign oor_c  = below_c || (off_c >= SPAN);
  assign bank_c = off_c[17:16];

  always_comb begin
    cs_c = '0;
    for (int k = 0; k < BANKS; k++) cs_c[k] = !oor_c && (bank_c == 2'(k));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = ISSUE;
      ISSUE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt1_q       <= 1'b0;
      bank_q       <= '0;
      oor_q        <= 1'b0;
      rd_q         <= 1'b0;
      bus.ram_cs   <= '0;
      bus.ram_wren <= '0;
      bus.ram_adr  <= '0;
      bus.ram_di   <= '0;
      bus.m0_ready <= 1'b0;
      bus.m1_ready <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.ram_wren <= '0;
      bus.m0_ready <= 1'b0;
      bus.m1_ready <= 1'b0;
      bus.err      <= 1'b0;
      case (state_q)
        IDLE: if (|req) begin
          gnt1_q       <= gnt[1];
          bank_q       <= bank_c;
          oor_q        <= oor_c;
          rd_q         <= (wstrb_c == 4'h0);
          bus.ram_cs   <= cs_c;
          bus.ram_adr  <= word_of(off_c);
          bus.ram_di   <= wdata_c;
          bus.ram_wren <= oor_c ? 4'h0 : wstrb_c;
        end
        ISSUE: begin
          bus.m0_ready <= ~gnt1_q;
          bus.m1_ready <= gnt1_q;
          bus.err      <= oor_q;
        end
        DONE:    bus.ram_cs <= '0;
        default: ;
      endcase
    end
  end

  // Chip select stays high through DONE, so the selected bank's output is live there.
  always_comb begin
    bank_do = '0;
    for (int k = 0; k < BANKS; k++)
      if (bank_q == 2'(k)) bank_do = bus.ram_do[32*k +: 32];
  end

  assign hit          = (state_q == DONE) && rd_q && !oor_q;
  assign bus.m0_rdata = (hit && !gnt1_q) ? bank_do : 32'h0;
  assign bus.m1_rdata = (hit &&  gnt1_q) ? bank_do : 32'h0;
endmodule

// File: tb/tb_spram_bus_ctrl.sv
// tb/tb_spram_bus_ctrl.sv - randomized and directed bench for spram_bus_ctrl
module tb_spram_bus_ctrl;
  localparam int          BANKS = 2;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam logic [31:0] SPAN  = 32'(BANKS) * 32'h0001_0000;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   total  = 0;
  int   bad    = 0;
  int   cyc    = 0;

  spram_bus_ctrl_if #(.BANKS(BANKS)) bus ();

  spram_bus_ctrl #(.BANKS(BANKS), .BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pre(input int b, input int w);
    return (32'h9E37_79B9 * 32'(b * 64 + w + 1)) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RAM banks: synchronous, registered output, zero output when deselected.
  logic [31:0]         ram_mem [BANKS][16384];
  logic [BANKS*32-1:0] ram_do_q = '0;
  assign bus.ram_do = ram_do_q;

  initial begin
    for (int b = 0; b < BANKS; b++)
      for (int w = 0; w < 16384; w++) ram_mem[b][w] = (w < 16) ? pre(b, w) : 32'h0;
    forever begin
      @(posedge clk);
      for (int b = 0; b < BANKS; b++) begin
        if (bus.ram_cs[b]) begin
          for (int j = 0; j < 4; j++)
            if (bus.ram_wren[j]) ram_mem[b][bus.ram_adr][8*j +: 8] = bus.ram_di[8*j +: 8];
          ram_do_q[32*b +: 32] <= ram_mem[b][bus.ram_adr];
        end else begin
          ram_do_q[32*b +: 32] <= 32'h0;
        end
      end
    end
  end

  // Reference model: one transaction at a time, ph counts cycles since acceptance.
  logic [31:0] ref_mem [BANKS][16384];
  int          ph = 0;
  int          last = 1;
  int          t_port, t_bank, t_word;
  bit          t_oor;
  logic [31:0] t_wdata, t_rexp;
  logic [3:0]  t_wstrb;

  initial begin
    logic [31:0] a, off;
    for (int b = 0; b < BANKS; b++)
      for (int w = 0; w < 16384; w++) ref_mem[b][w] = (w < 16) ? pre(b, w) : 32'h0;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        ph = 0;
        last = 1;
      end else if (ph == 0) begin
        if (bus.m0_valid || bus.m1_valid) begin
          if (bus.m0_valid && bus.m1_valid) t_port = 1 - last;
          else t_port = bus.m0_valid ? 0 : 1;
          last    = t_port;
          a       = t_port ? bus.m1_addr  : bus.m0_addr;
          t_wdata = t_port ? bus.m1_wdata : bus.m0_wdata;
          t_wstrb = t_port ? bus.m1_wstrb : bus.m0_wstrb;
          off     = a - BASE;
          t_oor   = (a < BASE) || (off >= SPAN);
          t_bank  = int'(off / 32'h0001_0000);
          t_word  = int'((off % 32'h0001_0000) / 4);
          t_rexp  = 32'h0;
          if (!t_oor && t_wstrb == 4'h0) t_rexp = ref_mem[t_bank][t_word];
          ph = 1;
        end
      end else if (ph == 1) begin
        if (!t_oor)
          for (int j = 0; j < 4; j++)
            if (t_wstrb[j]) ref_mem[t_bank][t_word][8*j +: 8] = t_wdata[8*j +: 8];
        ph = 2;
      end else begin
        ph = 0;
      end
    end
  end

  initial begin
    logic [31:0] e_cs, e_wren, e_d0, e_d1;
    bit e_r0, e_r1, e_err;
    forever begin
      @(negedge clk);
      e_cs = 0; e_wren = 0; e_d0 = 0; e_d1 = 0; e_r0 = 0; e_r1 = 0; e_err = 0;
      if (ph != 0 && !t_oor) e_cs = 32'd1 << t_bank;
      if (ph == 1 && !t_oor) e_wren = 32'(t_wstrb);
      if (ph == 2) begin
        if (t_port == 0) begin e_r0 = 1; e_d0 = t_rexp; end
        else             begin e_r1 = 1; e_d1 = t_rexp; end
        e_err = t_oor;
      end
      chk("m_cs",     32'(bus.ram_cs),   e_cs);
      chk("m_wren",   32'(bus.ram_wren), e_wren);
      chk("m_ready0", 32'(bus.m0_ready), 32'(e_r0));
      chk("m_ready1", 32'(bus.m1_ready), 32'(e_r1));
      chk("m_rdata0", bus.m0_rdata,      e_d0);
      chk("m_rdata1", bus.m1_rdata,      e_d1);
      chk("m_err",    32'(bus.err),      32'(e_err));
      if (ph != 0 && !t_oor) begin
        chk("m_adr", 32'(bus.ram_adr), 32'(t_word));
        chk("m_di",  bus.ram_di,       t_wdata);
      end
    end
  end

  logic [31:0] iss_cs, iss_adr, iss_wren;
  int          err_cnt, rdy_cyc;
  bit          cs_seen;

  task automatic set_port(input int p, input bit v, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ws);
    if (p == 0) begin
      bus.m0_valid = v; bus.m0_addr = a; bus.m0_wdata = wd; bus.m0_wstrb = ws;
    end else begin
      bus.m1_valid = v; bus.m1_addr = a; bus.m1_wdata = wd; bus.m1_wstrb = ws;
    end
  endtask

  task automatic do_req(input int p, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input bit hold,
                        output logic [31:0] rd, output int lat);
    int start;
    bit got, rdy;
    set_port(p, 1'b1, a, wd, ws);
    start = cyc; got = 0; rd = 'x; lat = -1; err_cnt = 0; cs_seen = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (i == 1) begin
        iss_cs = 32'(bus.ram_cs); iss_adr = 32'(bus.ram_adr); iss_wren = 32'(bus.ram_wren);
      end
      if (bus.ram_cs != '0) cs_seen = 1;
      if (bus.err) err_cnt++;
      rdy = (p == 0) ? bus.m0_ready : bus.m1_ready;
      if (rdy) begin
        got = 1;
        rd = (p == 0) ? bus.m0_rdata : bus.m1_rdata;
        lat = cyc - start;
        rdy_cyc = cyc;
      end
    end
    @(posedge clk); #1;
    if (!hold) set_port(p, 1'b0, a, wd, ws);
    chk("req_done", 32'(got), 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    set_port(0, 1'b0, 0, 0, 0);
    set_port(1, 1'b0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic new_req(input int p);
    logic [31:0] a;
    int k;
    k = $urandom_range(0, 9);
    if (k < 8)
      a = BASE + 32'h0001_0000 * $urandom_range(0, BANKS - 1) + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
    else if (k == 8) a = BASE + SPAN + 4 * $urandom_range(0, 255);
    else             a = BASE - 4 * $urandom_range(1, 64);
    set_port(p, 1'b1, a, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0);
  endtask

  task automatic run_random(input int cycles);
    bit r0, r1;
    for (int c = 0; c < cycles + 40; c++) begin
      @(negedge clk);
      r0 = bus.m0_ready; r1 = bus.m1_ready;
      @(posedge clk); #1;
      if (r0) set_port(0, 1'b0, 0, 0, 0);
      if (r1) set_port(1, 1'b0, 0, 0, 0);
      if (c < cycles) begin
        if (!bus.m0_valid && $urandom_range(0, 3) != 0) new_req(0);
        if (!bus.m1_valid && $urandom_range(0, 3) != 0) new_req(1);
      end else if (!bus.m0_valid && !bus.m1_valid) begin
        break;
      end
    end
    chk("rand_drain", 32'({bus.m0_valid, bus.m1_valid}), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, rd2;
    int lat, lat2, c1, n;
    int grants [8];
    bit r0, r1;

    set_port(0, 1'b0, 0, 0, 0);
    set_port(1, 1'b0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_cs",     32'(bus.ram_cs),   32'd0);
    chk("rst_wren",   32'(bus.ram_wren), 32'd0);
    chk("rst_adr",    32'(bus.ram_adr),  32'd0);
    chk("rst_di",     bus.ram_di,        32'd0);
    chk("rst_ready0", 32'(bus.m0_ready), 32'd0);
    chk("rst_rdata0", bus.m0_rdata,      32'd0);
    chk("rst_err",    32'(bus.err),      32'd0);
    @(posedge clk); #1 resetn = 1'b1;

    do_req(0, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, lat);
    chk("t1_iss_cs", iss_cs, 32'd1);
    chk("t1_iss_adr", iss_adr, 32'd4);
    chk("t1_iss_wren", iss_wren, 32'hF);
    chk("t1_wr_lat", 32'(lat), 32'd2);
    do_req(0, BASE + 32'h10, 32'h0, 4'h0, 1'b0, rd, lat);
    chk("t1_rd", rd, 32'hDEADBEEF);
    chk("t1_rd_lat", 32'(lat), 32'd2);

    do_req(1, BASE + 32'h1_0008, 32'h11223344, 4'hF, 1'b0, rd, lat);
    do_req(1, BASE + 32'h1_0008, 32'h00AA0000, 4'b0100, 1'b0, rd, lat);
    chk("t2_iss_cs", iss_cs, 32'd2);
    chk("t2_iss_adr", iss_adr, 32'd2);
    chk("t2_iss_wren", iss_wren, 32'h4);
    chk("t2_wr_rdata", rd, 32'h0);
    do_req(0, BASE + 32'h1_0008, 32'h0, 4'h0, 1'b0, rd, lat);
    chk("t2_rd", rd, 32'h11AA3344);

    do_req(0, BASE + SPAN, 32'h0, 4'h0, 1'b0, rd, lat);
    chk("t3_rd", rd, 32'h0);
    chk("t3_lat", 32'(lat), 32'd2);
    chk("t3_err_cnt", 32'(err_cnt), 32'd1);
    chk("t3_no_cs", 32'(cs_seen), 32'd0);
    do_req(1, BASE - 32'h4, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, lat);
    chk("t3_below_err", 32'(err_cnt), 32'd1);
    chk("t3_below_no_cs", 32'(cs_seen), 32'd0);

    do_req(0, BASE + 32'h4, 32'h0, 4'h0, 1'b1, rd, lat);
    c1 = rdy_cyc;
    do_req(0, BASE + 32'h1_0004, 32'h0, 4'h0, 1'b0, rd2, lat2);
    chk("t4_rd_b0", rd, pre(0, 1));
    chk("t4_rd_b1", rd2, pre(1, 1));
    chk("t4_lat0", 32'(lat), 32'd2);
    chk("t4_spacing", 32'(rdy_cyc - c1), 32'd3);

    set_port(0, 1'b1, BASE + 32'h190, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #2;
    chk("t5_issue_cs", 32'(bus.ram_cs), 32'd1);
    resetn = 1'b0;
    #1;
    chk("t5_rst_cs", 32'(bus.ram_cs), 32'd0);
    chk("t5_rst_wren", 32'(bus.ram_wren), 32'd0);
    chk("t5_rst_ready", 32'(bus.m0_ready), 32'd0);
    set_port(0, 1'b0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    do_req(0, BASE + 32'h14, 32'h0, 4'h0, 1'b0, rd, lat);
    chk("t5_after_rd", rd, pre(0, 5));
    chk("t5_after_lat", 32'(lat), 32'd2);

    pulse_reset();
    set_port(0, 1'b1, BASE + 32'h8, 32'h0, 4'h0);
    set_port(1, 1'b1, BASE + 32'h1_000C, 32'h0, 4'h0);
    n = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      @(negedge clk);
      r0 = bus.m0_ready; r1 = bus.m1_ready;
      if (r0 && n < 8) begin grants[n] = 0; n++; end
      if (r1 && n < 8) begin grants[n] = 1; n++; end
      @(posedge clk); #1;
      if (r0) set_port(0, 1'b1, BASE + 4 * $urandom_range(0, 15), 32'h0, 4'h0);
      if (r1) set_port(1, 1'b1, BASE + 32'h1_0000 + 4 * $urandom_range(0, 15), $urandom, 4'hF);
    end
    set_port(0, 1'b0, 0, 0, 0);
    set_port(1, 1'b0, 0, 0, 0);
    chk("t6_count", 32'(n), 32'd8);
    for (int i = 0; i < 8; i++) chk("t6_grant", 32'(grants[i]), 32'(i % 2));

    run_random(800);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spram_bus_ctrl.md
# spram_bus_ctrl

Initiator side of the 16Kx32 single-port RAM interface: accepts picorv32-native memory requests from two requesters (CPU and an auxiliary master such as a loader or DMA), arbitrates round-robin, decodes the byte address into a bank and word address, and drives the `cs`/`wren`/`adr`/`di` pins of up to four RAM banks. It returns `ready`/`rdata` per port and sits between the core bus and the banked SPRAM instances.

## Interface
Parameters:
- `BANKS`, 2, number of 16Kx32 banks (1..4); each bank spans 64 KiB.
- `BASE_ADDR`, 32'h0000_0000, byte address of bank 0 word 0; must be 64 KiB aligned.

Ports:
- `clk` in 1, single clock.
- `resetn` in 1, reset: asynchronous, active-low.
- `m0_valid` in 1, port 0 (CPU) request; held until `m0_ready`.
- `m0_addr` in 32, byte address; bits [1:0] ignored.
- `m0_wdata` in 32, write data.
- `m0_wstrb` in 4, byte write enables; 0000 = read.
- `m0_ready` out 1, one-cycle completion pulse.
- `m0_rdata` out 32, read data, valid while `m0_ready`.
- `m1_valid`, `m1_addr`, `m1_wdata`, `m1_wstrb`, `m1_ready`, `m1_rdata`: port 1 (aux), same widths and rules.
- `ram_cs` out BANKS, per-bank chip select, one-hot or zero.
- `ram_wren` out 4, byte write enables shared by all banks.
- `ram_adr` out 14, word address shared by all banks.
- `ram_di` out 32, write data shared by all banks.
- `ram_do` in BANKS*32, bank k read data at [32k+31:32k].
- `err` out 1, one-cycle pulse on out-of-range access.

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: if any `mX_valid`, grant one port (round-robin, see below), register its address/wdata/wstrb, compute `off = addr - BASE_ADDR`; bank = off[17:16], word = off[15:2]; go ISSUE.
- Out of range (`addr < BASE_ADDR` or `off >= BANKS*64KiB`): no `ram_cs`, go ISSUE then DONE anyway; DONE returns `rdata = 0`, write dropped, `err` pulses in DONE.
- ISSUE: `ram_cs[bank]=1`, `ram_adr=word`, `ram_di=wdata`, `ram_wren=wstrb`. Go DONE.
- DONE: `ram_cs[bank]` stays 1 (deselected banks output zero), `ram_wren=0`, `ram_adr` unchanged; granted `mX_ready=1`, `mX_rdata = ram_do[bank]` (reads) or 0 (writes). Go IDLE.
- Arbitration: single requester wins immediately; both valid in IDLE -> port not granted last wins; after reset port 0 has priority.
- Ungranted port's `ready` stays 0; its request waits, no state lost.
- Requests whose `valid` drops before `ready` are protocol violations; behaviour undefined, no hang required beyond completing the current access.

## Timing
- Request sampled in IDLE at edge N; ISSUE cycle N+1; DONE/`ready` cycle N+2; back to IDLE N+3. Fixed 2-cycle wait, 3 cycles per transaction, reads and writes alike.
- Back-to-back: `valid` held high with a new address in the cycle after `ready` is accepted as a new request at that edge.
- All outputs registered from state; none combinational from `mX_valid`.
- Reset values: state IDLE, `ram_cs=0`, `ram_wren=0`, `ram_adr=0`, `ram_di=0`, `m0_ready=m1_ready=0`, `mX_rdata=0`, `err=0`, last-grant = port 1 (so port 0 wins first).
- Reset asserted mid-ISSUE: write may or may not land in RAM; all outputs return to reset values asynchronously; no `ready` issued for the aborted access.

## Structure
- Package `spram_bus_pkg`: state enum (IDLE/ISSUE/DONE), `BANK_WORDS=16384`, `BANK_BYTES=65536`, `ADR_W=14`.
- Sub-module `rr_arb2`: two requests, enable from IDLE, outputs one-hot grant and updates last-grant register.
- Bench instantiates the existing 16Kx32 RAM model per bank behind `ram_*`.

## Test plan
- Port 0 write 32'hDEADBEEF, wstrb 1111, addr BASE+0x10 -> `ram_cs[0]`, `ram_adr=4` in N+1; readback returns 32'hDEADBEEF with `m0_ready` at N+2.
- Byte write wstrb 0100, wdata 32'h00AA0000 over 32'h11223344 at BASE+0x1_0008 -> bank 1 word 2 reads 32'h11AA3344.
- Both ports valid every cycle for 8 transactions -> grants alternate 0,1,0,1…, first grant port 0, no starvation.
- Read at BASE+BANKS*64KiB -> `rdata=0`, `ready` at N+2, `err` one pulse, no `ram_cs` ever high.
- Back-to-back port 0 reads to banks 0 then 1 -> `ready` at N+2 and N+5, correct bank data each.
- `resetn` low during ISSUE -> `ram_cs`, `ram_wren`, `ready` drop to 0 immediately; after release, port 0 read completes normally.
